// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } mdu_state_e;

    // Cycles from the accepting edge to the write cycle, inclusive.
    localparam int unsigned MDU_LATENCY = 34;

endpackage

// File: rtl/mdu_iter_core.sv
// One radix-2 step per cycle on a 2*WIDTH+1 accumulator.
// Multiply: shift-add, multiplier starts in the low half, product ends in [2W-1:0].
// Divide: restoring shift-subtract, quotient ends in [W-1:0], remainder in [2W-1:W].
module mdu_iter_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic                 div_mode,
    input  logic [WIDTH-1:0]     a_mag,
    input  logic [WIDTH:0]       b_mag,
    output logic [2*WIDTH-1:0]   result
);

    logic [2*WIDTH:0] acc_q, acc_d;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH+1:0] sub_diff;

    // Load operand or advance by one shift-add / shift-subtract step.
    always_comb begin
        acc_d    = acc_q;
        add_sum  = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? b_mag : '0);
        rem_sh   = acc_q[2*WIDTH:WIDTH-1];
        sub_diff = rem_sh - {1'b0, b_mag};
        if (load) begin
            acc_d = {{(WIDTH+1){1'b0}}, a_mag};
        end else if (step) begin
            if (div_mode) begin
                if (!sub_diff[WIDTH+1]) begin
                    acc_d = {sub_diff[WIDTH:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {rem_sh[WIDTH:0], acc_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d = {1'b0, add_sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign result = acc_q[2*WIDTH-1:0];

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit driving the HI/LO write ports.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             hi_w_en,
    output logic [WIDTH-1:0] hi_w_data,
    output logic             lo_w_en,
    output logic [WIDTH-1:0] lo_w_data
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    mdu_state_e       state_q, state_d;
    mdu_op_e          op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             res_neg_q, res_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH:0]   b_mag_q, b_mag_d;
    logic [WIDTH-1:0] hi_data_q, hi_data_d;
    logic [WIDTH-1:0] lo_data_q, lo_data_d;

    logic               accept;
    logic               op_signed;
    logic               is_div;
    logic               write_ok;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_abs;
    logic [2*WIDTH-1:0] core_result;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    // A new op is taken in IDLE or in the DONE cycle (overlapping the HI/LO write).
    assign accept    = start && !flush && (state_q == ST_IDLE || state_q == ST_DONE);
    assign op_signed = !op[0];
    assign a_mag     = (op_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    assign b_abs     = (op_signed && src_b[WIDTH-1]) ? -src_b : src_b;
    assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign write_ok  = !(is_div && div_zero_q);

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .step     (state_q == ST_CALC),
        .div_mode (is_div),
        .a_mag    (a_mag),
        .b_mag    (b_mag_q),
        .result   (core_result)
    );

    // Sign correction of the unsigned core result.
    always_comb begin
        prod_fixed = (op_q == OP_MULT && res_neg_q) ? -core_result : core_result;
        quo_fixed  = (op_q == OP_DIV && res_neg_q) ? -core_result[WIDTH-1:0]
                                                   : core_result[WIDTH-1:0];
        rem_fixed  = (op_q == OP_DIV && rem_neg_q) ? -core_result[2*WIDTH-1:WIDTH]
                                                   : core_result[2*WIDTH-1:WIDTH];
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_MULT;
            cnt_q      <= '0;
            res_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            b_mag_q    <= '0;
            hi_data_q  <= '0;
            lo_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            res_neg_q  <= res_neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
            b_mag_q    <= b_mag_d;
            hi_data_q  <= hi_data_d;
            lo_data_q  <= lo_data_d;
        end
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start) state_d = ST_CALC;
                ST_CALC: if (cnt_q == '0) state_d = ST_FIX;
                ST_FIX:  state_d = ST_DONE;
                ST_DONE: state_d = start ? ST_CALC : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Operand latch, step counter and result capture at the end of FIX.
    always_comb begin
        op_d       = op_q;
        cnt_d      = cnt_q;
        res_neg_d  = res_neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        b_mag_d    = b_mag_q;
        hi_data_d  = hi_data_q;
        lo_data_d  = lo_data_q;
        if (flush) begin
            cnt_d = '0;
        end else if (accept) begin
            op_d       = mdu_op_e'(op);
            cnt_d      = CNT_W'(WIDTH - 1);
            res_neg_d  = op_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            rem_neg_d  = op_signed && src_a[WIDTH-1];
            div_zero_d = (src_b == '0);
            b_mag_d    = {1'b0, b_abs};
        end else if (state_q == ST_CALC && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (state_q == ST_FIX && write_ok) begin
            if (is_div) begin
                hi_data_d = rem_fixed;
                lo_data_d = quo_fixed;
            end else begin
                hi_data_d = prod_fixed[2*WIDTH-1:WIDTH];
                lo_data_d = prod_fixed[WIDTH-1:0];
            end
        end
    end

    // Outputs decoded from state; flush suppresses the completion pulse and write.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE) && !flush;
        hi_w_en   = done && write_ok;
        lo_w_en   = done && write_ok;
        hi_w_data = hi_data_q;
        lo_w_data = lo_data_q;
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit.
module tb_mul_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        flush = 1'b0;
    logic        busy, done, hi_w_en, lo_w_en;
    logic [31:0] hi_w_data, lo_w_data;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_hi_last = '0;
    logic [31:0] exp_lo_last = '0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .hi_w_en   (hi_w_en),
        .hi_w_data (hi_w_data),
        .lo_w_en   (lo_w_en),
        .lo_w_data (lo_w_data)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain 64-bit arithmetic. SV '/' truncates toward zero and '%'
    // takes the dividend's sign, matching the architectural definition.
    function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                      output logic wr, output logic [31:0] hi, output logic [31:0] lo);
        logic signed [63:0] sa, sb, sp;
        logic [63:0] up;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        wr = 1'b1;
        hi = '0;
        lo = '0;
        case (o)
            2'b00: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
            2'b01: begin up = {32'b0, a} * {32'b0, b}; hi = up[63:32]; lo = up[31:0]; end
            2'b10: begin
                if (b == 0) wr = 1'b0;
                else begin sp = sa / sb; lo = sp[31:0]; sp = sa % sb; hi = sp[31:0]; end
            end
            default: begin
                if (b == 0) wr = 1'b0;
                else begin lo = a / b; hi = a % b; end
            end
        endcase
    endfunction

    // Issue one op and observe 40 cycles. With noisy=1, extra start pulses with
    // random operands are issued while the unit is busy.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit noisy,
                          output int busy_cnt, output int busy_last, output int done_cyc, output int done_cnt,
                          output int en_cyc, output int en_cnt, output int split,
                          output logic [31:0] hi, output logic [31:0] lo);
        busy_cnt = 0; busy_last = 0; done_cyc = 0; done_cnt = 0;
        en_cyc = 0; en_cnt = 0; split = 0; hi = '0; lo = '0;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk); #1;
        for (int c = 1; c <= 40; c++) begin
            if (noisy && c < 34 && (c % 7) == 0) begin
                start = 1'b1; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
            end else begin
                start = 1'b0;
            end
            if (busy) begin busy_cnt++; busy_last = c; end
            if (done) begin done_cnt++; if (done_cyc == 0) done_cyc = c; end
            if (hi_w_en !== lo_w_en) split++;
            if (hi_w_en) begin en_cnt++; en_cyc = c; hi = hi_w_data; lo = lo_w_data; end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({busy, done, hi_w_en, lo_w_en, hi_w_data, lo_w_data} !== '0)
            $display("FAIL reset_state: busy=%b done=%b hi_en=%b lo_en=%b hi=%h lo=%h, expected all 0",
                     busy, done, hi_w_en, lo_w_en, hi_w_data, lo_w_data);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: busy=%b expected 0", busy);
        end
        exp_hi_last = '0;
        exp_lo_last = '0;
    endtask

    task automatic test_known_vectors();
        logic [1:0]  ops [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11, 2'b00, 2'b10};
        logic [31:0] as  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd100,
                                 32'h80000000, 32'd5, 32'h80000000, 32'd7};
        logic [31:0] bs  [8] = '{32'h2, 32'h2, 32'h2, 32'd7,
                                 32'hFFFFFFFF, 32'h0, 32'h80000000, 32'hFFFFFFFE};
        int bc, bl, dc, dn, ec, en, sp;
        logic [31:0] hi, lo, ehi, elo;
        logic wr;
        for (int i = 0; i < 8; i++) begin
            ref_model(ops[i], as[i], bs[i], wr, ehi, elo);
            run_op(ops[i], as[i], bs[i], 1'b0, bc, bl, dc, dn, ec, en, sp, hi, lo);
            tests_run++;
            if (dc != int'(MDU_LATENCY) || dn != 1) begin
                tests_failed++;
                $display("FAIL vec%0d_done: first cycle %0d count %0d, expected cycle 34 count 1", i, dc, dn);
            end
            tests_run++;
            if (bc != int'(MDU_LATENCY) || bl != int'(MDU_LATENCY)) begin
                tests_failed++;
                $display("FAIL vec%0d_busy: %0d cycles ending %0d, expected cycles 1-34", i, bc, bl);
            end
            tests_run++;
            if (en != (wr ? 1 : 0) || (wr && ec != int'(MDU_LATENCY)) || sp != 0) begin
                tests_failed++;
                $display("FAIL vec%0d_wen: count %0d at cycle %0d split %0d, expected count %0d at 34",
                         i, en, ec, sp, wr ? 1 : 0);
            end
            if (wr) begin
                tests_run++;
                if (hi !== ehi || lo !== elo) begin
                    tests_failed++;
                    $display("FAIL vec%0d_result: hi=%h lo=%h, expected hi=%h lo=%h", i, hi, lo, ehi, elo);
                end
                exp_hi_last = ehi;
                exp_lo_last = elo;
            end
            tests_run++;
            if (hi_w_data !== exp_hi_last || lo_w_data !== exp_lo_last) begin
                tests_failed++;
                $display("FAIL vec%0d_hold: hi=%h lo=%h, expected hi=%h lo=%h",
                         i, hi_w_data, lo_w_data, exp_hi_last, exp_lo_last);
            end
        end
    endtask

    task automatic test_flush();
        int bc, bl, dc, dn, ec, en, sp, seen;
        logic [31:0] hi, lo;
        seen = 0;
        @(negedge clk);
        start = 1'b1; op = 2'b10; src_a = 32'd1000; src_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (done || hi_w_en || lo_w_en) seen++;
            @(posedge clk); #1;
        end
        flush = 1'b1;
        if (done || hi_w_en || lo_w_en) seen++;
        @(posedge clk); #1;
        flush = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_busy: busy=%b in cycle 11, expected 0", busy);
        end
        run_op(2'b01, 32'd3, 32'd4, 1'b0, bc, bl, dc, dn, ec, en, sp, hi, lo);
        tests_run++;
        if (seen != 0 || en != 1 || ec != int'(MDU_LATENCY) || dc != int'(MDU_LATENCY)) begin
            tests_failed++;
            $display("FAIL flush_no_write: flushed-op pulses %0d, next op en %0d at %0d done %0d, expected 0,1,34,34",
                     seen, en, ec, dc);
        end
        tests_run++;
        if (hi !== 32'h0 || lo !== 32'h0000000C) begin
            tests_failed++;
            $display("FAIL flush_next_op: hi=%h lo=%h, expected hi=00000000 lo=0000000c", hi, lo);
        end
        exp_hi_last = 32'h0;
        exp_lo_last = 32'h0000000C;
        // flush together with start in IDLE drops the start
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b00; src_a = 32'd9; src_b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (busy || done) seen++;
            @(posedge clk); #1;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("FAIL flush_beats_start: busy/done seen %0d cycles, expected 0", seen);
        end
    endtask

    task automatic test_async_reset();
        int bc, bl, dc, dn, ec, en, sp;
        logic [31:0] hi, lo, ehi, elo;
        logic wr;
        @(negedge clk);
        start = 1'b1; op = 2'b00; src_a = 32'h12345678; src_b = 32'h9ABCDEF0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #3;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_busy: busy=%b in cycle 20, expected 1", busy);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, hi_w_en, lo_w_en, hi_w_data, lo_w_data} !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: busy=%b done=%b hi_en=%b lo_en=%b hi=%h lo=%h, expected all 0",
                     busy, done, hi_w_en, lo_w_en, hi_w_data, lo_w_data);
        end
        exp_hi_last = '0;
        exp_lo_last = '0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: busy=%b expected 0", busy);
        end
        ref_model(2'b00, 32'hFFFF0001, 32'h00012345, wr, ehi, elo);
        run_op(2'b00, 32'hFFFF0001, 32'h00012345, 1'b1, bc, bl, dc, dn, ec, en, sp, hi, lo);
        tests_run++;
        if (dc != int'(MDU_LATENCY) || en != 1 || bc != int'(MDU_LATENCY) || hi !== ehi || lo !== elo) begin
            tests_failed++;
            $display("FAIL start_ignored_busy: done %0d en %0d busy %0d hi=%h lo=%h, expected 34,1,34 hi=%h lo=%h",
                     dc, en, bc, hi, lo, ehi, elo);
        end
        exp_hi_last = ehi;
        exp_lo_last = elo;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, ehi, elo, hi, lo;
        logic wr;
        int dc;
        a1 = $urandom; b1 = $urandom;
        a2 = $urandom; b2 = $urandom | 32'h1;
        @(negedge clk);
        start = 1'b1; op = 2'b00; src_a = a1; src_b = b1;
        @(posedge clk); #1;
        for (int c = 1; c < 34; c++) begin
            src_a = $urandom; src_b = $urandom;
            @(posedge clk); #1;
        end
        ref_model(2'b00, a1, b1, wr, ehi, elo);
        tests_run++;
        if (done !== 1'b1 || hi_w_en !== 1'b1 || hi_w_data !== ehi || lo_w_data !== elo) begin
            tests_failed++;
            $display("FAIL b2b_first: done=%b en=%b hi=%h lo=%h, expected 1,1 hi=%h lo=%h",
                     done, hi_w_en, hi_w_data, lo_w_data, ehi, elo);
        end
        op = 2'b10; src_a = a2; src_b = b2;
        @(posedge clk); #1;
        start = 1'b0;
        dc = 0; hi = '0; lo = '0;
        for (int c = 1; c <= 40; c++) begin
            if (hi_w_en && dc == 0) begin dc = c; hi = hi_w_data; lo = lo_w_data; end
            @(posedge clk); #1;
        end
        ref_model(2'b10, a2, b2, wr, ehi, elo);
        tests_run++;
        if (dc != int'(MDU_LATENCY) || hi !== ehi || lo !== elo) begin
            tests_failed++;
            $display("FAIL b2b_second: write cycle %0d hi=%h lo=%h, expected 34 hi=%h lo=%h",
                     dc, hi, lo, ehi, elo);
        end
        exp_hi_last = ehi;
        exp_lo_last = elo;
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0: v = $urandom_range(0, 15);
            1: v = -$urandom_range(1, 15);
            2: case ($urandom_range(0, 3))
                   0: v = 32'h80000000;
                   1: v = 32'hFFFFFFFF;
                   2: v = 32'h7FFFFFFF;
                   default: v = 32'h0;
               endcase
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic test_random();
        int bc, bl, dc, dn, ec, en, sp;
        logic [31:0] a, b, hi, lo, ehi, elo;
        logic [1:0] o;
        logic wr;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom);
            a = pick_operand();
            b = pick_operand();
            ref_model(o, a, b, wr, ehi, elo);
            run_op(o, a, b, (i % 3) == 0, bc, bl, dc, dn, ec, en, sp, hi, lo);
            tests_run++;
            if (dc != int'(MDU_LATENCY) || dn != 1 || bc != int'(MDU_LATENCY) || bl != int'(MDU_LATENCY)) begin
                tests_failed++;
                $display("FAIL rnd%0d_timing: done %0d/%0d busy %0d ending %0d, expected 34/1 busy 34 ending 34",
                         i, dc, dn, bc, bl);
            end
            tests_run++;
            if (en != (wr ? 1 : 0) || sp != 0 || (wr && (hi !== ehi || lo !== elo))) begin
                tests_failed++;
                $display("FAIL rnd%0d_result: op=%0d a=%h b=%h en=%0d hi=%h lo=%h, expected en=%0d hi=%h lo=%h",
                         i, o, a, b, en, hi, lo, wr ? 1 : 0, ehi, elo);
            end
            if (wr) begin
                exp_hi_last = ehi;
                exp_lo_last = elo;
            end
            tests_run++;
            if (hi_w_data !== exp_hi_last || lo_w_data !== exp_lo_last) begin
                tests_failed++;
                $display("FAIL rnd%0d_hold: hi=%h lo=%h, expected hi=%h lo=%h",
                         i, hi_w_data, lo_w_data, exp_hi_last, exp_lo_last);
            end
        end
    endtask

    initial begin
        test_reset();
        test_known_vectors();
        test_flush();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
